// File: rtl/pipelined_segmented_adder.sv
// Pipelined WIDTH-bit adder resolving one SEG-bit segment per stage, with an
// optional per-transaction cut of the low inter-segment carries.
module pipelined_segmented_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [AW-1:0]    approx_segs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned NSEG = (WIDTH / SEG < 1) ? 1 : WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("pipelined_segmented_adder: WIDTH must be a multiple of SEG");
  end
  if ((32'd1 << AW) <= NSEG) begin : g_bad_aw
    $error("pipelined_segmented_adder: 2**AW must exceed WIDTH/SEG");
  end

  // Whole pipeline moves in lockstep whenever the output slot can take data.
  logic adv_c;
  assign adv_c    = !out_valid | out_ready;
  assign in_ready = adv_c;

  for (genvar j = 0; j < NSEG; j++) begin : g_stage
    // Operand bits still to be added when entering stage j.
    localparam int unsigned REM = WIDTH - j * SEG;

    logic             vi;
    logic [REM-1:0]   ai;
    logic [REM-1:0]   bi;
    logic             ci;
    logic [WIDTH-1:0] si;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] sum_d;

    if (j == 0) begin : g_src
      assign vi = in_valid;
      assign ai = in_a;
      assign bi = in_b;
      assign ci = in_cin;
      assign si = '0;
    end else begin : g_src
      assign vi = g_stage[j-1].g_mid.vld_q;
      assign ai = g_stage[j-1].g_mid.opa_q;
      assign bi = g_stage[j-1].g_mid.opb_q;
      assign ci = g_stage[j-1].g_mid.cy_q;
      assign si = g_stage[j-1].g_mid.sum_q;
    end

    assign seg_sum = {1'b0, ai[SEG-1:0]} + {1'b0, bi[SEG-1:0]} + (SEG+1)'(ci);
    assign sum_d   = si | (WIDTH'(seg_sum[SEG-1:0]) << (j * SEG));

    if (j < NSEG - 1) begin : g_mid
      logic [AW-1:0]      api;
      logic               vld_q;
      logic               cy_q;
      logic               cy_d;
      logic [WIDTH-1:0]   sum_q;
      logic [REM-SEG-1:0] opa_q;
      logic [REM-SEG-1:0] opb_q;
      logic [REM-SEG-1:0] opa_d;
      logic [REM-SEG-1:0] opb_d;
      logic [AW-1:0]      ap_q;

      if (j == 0) begin : g_ap
        assign api = approx_segs;
      end else begin : g_ap
        assign api = g_stage[j-1].g_mid.ap_q;
      end

      // Carry into segment j+1 is cut when j+1 <= approx_segs.
      assign cy_d  = (32'(api) > 32'(j)) ? 1'b0 : seg_sum[SEG];
      assign opa_d = ai[REM-1:SEG];
      assign opb_d = bi[REM-1:SEG];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          cy_q  <= 1'b0;
          sum_q <= '0;
          opa_q <= '0;
          opb_q <= '0;
          ap_q  <= '0;
        end else if (adv_c) begin
          vld_q <= vi;
          if (vi) begin
            cy_q  <= cy_d;
            sum_q <= sum_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            ap_q  <= api;
          end
        end
      end
    end else begin : g_last
      logic             vld_q;
      logic             cy_q;
      logic [WIDTH-1:0] sum_q;

      // Final stage doubles as the output register; its carry-out is never cut.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          cy_q  <= 1'b0;
          sum_q <= '0;
        end else if (adv_c) begin
          vld_q <= vi;
          if (vi) begin
            cy_q  <= seg_sum[SEG];
            sum_q <= sum_d;
          end
        end
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].g_last.vld_q;
  assign out_sum   = g_stage[NSEG-1].g_last.sum_q;
  assign out_cout  = g_stage[NSEG-1].g_last.cy_q;

endmodule
